// File: rtl/vga_vram_arbiter.sv
// Shares one synchronous single-port video RAM between the VGA scan-out path
// and a CPU port; display fetches take the port every fourth visible cycle.
module vga_vram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_blank,
    input  logic        v_blank,
    input  logic        v_blank_end,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [13:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [1:0]  pix_data,
    output logic        pix_valid,
    output logic [1:0]  dbg_state
);

    // CPU handshake: cpu_req is a level request that may be held or dropped
    // after the issue cycle; cpu_ack pulses once, and cpu_rdata is valid with it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } cpu_state_e;

    cpu_state_e  state_q, state_d;
    logic [7:0]  col_q, col_d;
    logic [1:0]  sub_q, sub_d;
    logic [13:0] row_base_q, row_base_d;
    logic        h_blank_q;
    logic        disp_load_q;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  vis_q;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;

    logic        visible;
    logic        disp_slot;
    logic        line_end;
    logic [13:0] disp_addr;

    assign visible   = !h_blank && !v_blank;
    assign disp_slot = visible && (col_q[1:0] == 2'd0);
    assign line_end  = h_blank && !h_blank_q && !v_blank;
    assign disp_addr = row_base_q + {8'd0, col_q[7:2]};

    assign cpu_rdata = cpu_rdata_q;
    assign pix_data  = shift_q[7:6];
    assign pix_valid = vis_q[1];
    assign dbg_state = state_q;

    // Scan position, line/row tracking and the pixel shifter.
    always_comb begin
        col_d      = visible ? col_q + 8'd1 : 8'd0;
        sub_d      = sub_q;
        row_base_d = row_base_q;
        if (v_blank_end) begin
            sub_d      = 2'd0;
            row_base_d = 14'd0;
        end else if (line_end) begin
            sub_d = sub_q + 2'd1;
            if (sub_q == 2'd3) begin
                row_base_d = row_base_q + 14'd64;
            end
        end
        shift_d = disp_load_q ? ram_rdata : {shift_q[5:0], 2'b00};
    end

    // CPU FSM and RAM port mux; the display slot always owns the port.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack     = 1'b0;
        ram_addr    = 14'd0;
        ram_we      = 1'b0;
        ram_wdata   = 8'd0;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && !disp_slot) begin
                    ram_addr  = cpu_addr;
                    ram_we    = cpu_we;
                    ram_wdata = cpu_wdata;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cpu_rdata_d = ram_rdata;
                state_d     = ST_ACK;
            end
            ST_ACK: begin
                cpu_ack = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= 8'd0;
            sub_q       <= 2'd0;
            row_base_q  <= 14'd0;
            h_blank_q   <= 1'b1;
            disp_load_q <= 1'b0;
            shift_q     <= 8'd0;
            vis_q       <= 2'b00;
            cpu_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            sub_q       <= sub_d;
            row_base_q  <= row_base_d;
            h_blank_q   <= h_blank;
            disp_load_q <= disp_slot;
            shift_q     <= shift_d;
            vis_q       <= {vis_q[0], visible};
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

endmodule

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 SHALL have ports: clk in 1, pixel clock (16 MHz); rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: h_blank, v_blank, v_blank_end in 1 each, from the VGA timing generator, synchronous to clk.
REQ-003 SHALL have ports: cpu_req in 1, level access request; cpu_we in 1, write enable; cpu_addr in 14, word address; cpu_wdata in 8, write data.
REQ-004 SHALL have ports: cpu_ack out 1, one-cycle completion pulse; cpu_rdata out 8, read data valid with cpu_ack.
REQ-005 SHALL have ports: ram_addr out 14; ram_we out 1; ram_wdata out 8; ram_rdata in 8 (single-port video RAM, synchronous read, 1-cycle latency).
REQ-006 SHALL have ports: pix_data out 2, macropixel colour; pix_valid out 1, pix_data meaningful.

Function
REQ-007 visible = !h_blank & !v_blank (combinational); col[7:0] SHALL clear when !visible, else increment each cycle (0..255).
REQ-008 disp_slot = visible & (col[1:0]==0); each RAM byte holds 4 pixels, MSB pair first.
REQ-009 Line tracking: h_blank_d registers h_blank; line_end = h_blank & !h_blank_d & !v_blank.
REQ-010 On line_end sub[1:0] SHALL increment; when sub wraps 3->0, row_base[13:0] SHALL add 64 (one RAM row = 4 display lines).
REQ-011 v_blank_end SHALL clear sub and row_base, taking priority over a simultaneous line_end.
REQ-012 In a disp_slot cycle: ram_addr = row_base + col[7:2], ram_we = 0; display always wins the port.
REQ-013 Pixel path: cycle after disp_slot, shift register SHALL load ram_rdata; other cycles shift left by 2; pix_data = shift[7:6] registered.
REQ-014 pix_valid SHALL equal visible delayed 2 cycles; the first pixel of a line appears 2 cycles after the first visible cycle, 256 pixels per line.
REQ-015 CPU FSM states: IDLE, WAIT, ACK.
REQ-016 IDLE: if cpu_req & !disp_slot, drive ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata this cycle and go to WAIT; otherwise stay in IDLE.
REQ-017 WAIT: cpu_rdata <= ram_rdata (also on writes); go to ACK.
REQ-018 ACK: cpu_ack = 1 for exactly this cycle; go to IDLE; a new access is not issued before the next IDLE cycle.
REQ-019 ram_we SHALL be 1 only in an IDLE issue cycle with cpu_we=1; when neither port is active, ram_addr=0, ram_we=0, ram_wdata=0.
REQ-020 cpu_req deasserted in WAIT/ACK SHALL NOT abort the access; ack still pulses.
REQ-021 cpu_addr/we/wdata SHALL be sampled only in the issue cycle.
REQ-022 Worst-case CPU latency from req to ack SHALL be 4 cycles (one disp_slot stall + issue + WAIT + ACK).
REQ-023 During v_blank or h_blank the CPU SHALL never stall.

Reset
REQ-024 rst_n low SHALL asynchronously force: FSM=IDLE, cpu_ack=0, cpu_rdata=0, pix_data=0, pix_valid=0, col=0, sub=0, row_base=0, h_blank_d=1, shift register=0.
REQ-025 Reset mid-access SHALL drop the access with no ack; the first CPU issue is allowed on the first clk edge after rst_n rises.

Verification
REQ-026 Blanking write/read: v_blank=1, write 0xA5 to 0x0123, then read 0x0123 -> issue on the req cycle, cpu_ack 2 cycles later, cpu_rdata=0xA5.
REQ-027 Contention: cpu_req asserted on a disp_slot cycle -> ram_addr carries the display address, CPU issues next cycle, ack at req+3.
REQ-028 Pixel order: RAM[0]=0x1B, first visible line -> pix_data sequence 0,1,2,3 starting 2 cycles after visible rises, pix_valid high 256 cycles.
REQ-029 Row stepping: run 8 visible lines -> fetch addresses 0..63 on lines 0-3, 64..127 on lines 4-7; v_blank_end pulse -> next frame fetches from 0.
REQ-030 Abort: rst_n low during WAIT -> no cpu_ack and all outputs 0; after release a read completes normally.
REQ-031 Req drop: cpu_req deasserted in WAIT -> cpu_ack still pulses once, FSM returns to IDLE with no second access.
